// File: rtl/zeroriscy_trace_checker.sv
// Compares the core's retire stream against golden retire records buffered in a FIFO.
// Latches the first divergence (or an unmatched retire) and keeps retire/match counters.
module zeroriscy_trace_checker #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      gold_valid,
    output logic                      gold_ready,
    input  logic [31:0]               gold_pc,
    input  logic [31:0]               gold_instr,
    input  logic [REG_ADDR_WIDTH-1:0] gold_rd,
    input  logic [31:0]               gold_wdata,
    input  logic                      retire_valid,
    input  logic [31:0]               retire_pc,
    input  logic [31:0]               retire_instr,
    input  logic [REG_ADDR_WIDTH-1:0] retire_rd,
    input  logic [31:0]               retire_wdata,
    output logic                      mismatch,
    output logic                      error,
    output logic                      underflow,
    output logic [31:0]               err_pc,
    output logic [2:0]                err_field,
    output logic [CNT_WIDTH-1:0]      retire_count,
    output logic [CNT_WIDTH-1:0]      match_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]               pc;
        logic [31:0]               instr;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [31:0]               wdata;
    } rec_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERROR} state_e;

    state_e               state_q, state_d;
    rec_t                 mem_q [DEPTH];
    rec_t                 mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 mismatch_q, mismatch_d;
    logic                 error_q, error_d;
    logic                 underflow_q, underflow_d;
    logic [31:0]          err_pc_q, err_pc_d;
    logic [2:0]           err_field_q, err_field_d;
    logic [CNT_WIDTH-1:0] retire_count_q, retire_count_d;
    logic [CNT_WIDTH-1:0] match_count_q, match_count_d;

    rec_t       head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       consume;
    logic [2:0] field;

    assign full       = (level_q == LVL_W'(DEPTH));
    assign empty      = (level_q == '0);
    // Ready looks only at registered state, plus rst so nothing is taken while in reset.
    assign gold_ready = !rst && !full && (state_q != ST_ERROR);
    assign push       = gold_valid && gold_ready;
    assign consume    = (state_q == ST_RUN) && retire_valid;
    assign pop        = consume && !empty;
    assign head       = mem_q[rd_ptr_q];

    assign field[0] = (head.pc != retire_pc);
    assign field[1] = (head.instr != retire_instr);
    assign field[2] = (head.rd != retire_rd) || ((head.rd != '0) && (head.wdata != retire_wdata));

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: gold_pc, instr: gold_instr, rd: gold_rd, wdata: gold_wdata};
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        mismatch_d     = 1'b0;
        error_d        = error_q;
        underflow_d    = underflow_q;
        err_pc_d       = err_pc_q;
        err_field_d    = err_field_q;
        retire_count_d = retire_count_q;
        match_count_d  = match_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (consume && empty) begin
                    underflow_d = 1'b1;
                    error_d     = 1'b1;
                    mismatch_d  = 1'b1;
                    err_pc_d    = retire_pc;
                    err_field_d = 3'b000;
                    state_d     = ST_ERROR;
                end else if (pop) begin
                    if (retire_count_q != '1) begin
                        retire_count_d = retire_count_q + CNT_WIDTH'(1);
                    end
                    if (field == 3'b000) begin
                        if (match_count_q != '1) begin
                            match_count_d = match_count_q + CNT_WIDTH'(1);
                        end
                        if (!enable) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        error_d     = 1'b1;
                        mismatch_d  = 1'b1;
                        err_pc_d    = retire_pc;
                        err_field_d = field;
                        state_d     = ST_ERROR;
                    end
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_ERROR;
        endcase
    end

    // Storage array carries no reset; level and pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            mismatch_q     <= 1'b0;
            error_q        <= 1'b0;
            underflow_q    <= 1'b0;
            err_pc_q       <= '0;
            err_field_q    <= '0;
            retire_count_q <= '0;
            match_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            mismatch_q     <= mismatch_d;
            error_q        <= error_d;
            underflow_q    <= underflow_d;
            err_pc_q       <= err_pc_d;
            err_field_q    <= err_field_d;
            retire_count_q <= retire_count_d;
            match_count_q  <= match_count_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign error        = error_q;
    assign underflow    = underflow_q;
    assign err_pc       = err_pc_q;
    assign err_field    = err_field_q;
    assign retire_count = retire_count_q;
    assign match_count  = match_count_q;
    assign fifo_level   = level_q;

endmodule
